// File: rtl/hex_page_sched.sv
// Eight-digit HEX display scheduler: rotates valid sources on a dwell timer, with urgent preemption.
// Optional feature: define HEXSCHED_BLINK_EN to blink the display during an urgent grant.
module hex_page_sched #(
    parameter int unsigned NSRC       = 4,
    parameter int unsigned DWELL      = 50_000_000,
    parameter int unsigned HOLD       = 100_000_000,
    parameter int unsigned BLINK_HALF = 12_500_000
) (
    input  logic                 iCLK_50,
    input  logic                 iRST_N,
    input  logic [NSRC*32-1:0]   iSRC_DATA,
    input  logic [NSRC-1:0]      iSRC_VALID,
    input  logic [NSRC-1:0]      iURG_REQ,
    output logic [NSRC-1:0]      oURG_GNT,
    input  logic                 iFREEZE,
    output logic [31:0]          oDIGITS,
    output logic [7:0]           oBLANK,
    output logic [2:0]           oPAGE,
    output logic [1:0]           oMODE
);

    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    if (NSRC < 2 || NSRC > 8 || DWELL == 0 || HOLD == 0 || BLINK_HALF == 0) begin : g_param_err
        $error("hex_page_sched: parameter out of range");
    end

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRotate = 2'd1,
        StUrgent = 2'd2
    } mode_e;

    mode_e             r_mode, w_mode_d;
    logic [2:0]        r_page, w_page_d;
    logic [DW-1:0]     r_dwell, w_dwell_d;
    logic [HW-1:0]     r_hold, w_hold_d;
    logic [NSRC-1:0]   r_armed, w_armed_d;
    logic [NSRC-1:0]   r_gnt, w_gnt_d;
    logic [31:0]       r_digits, w_digits_d;
    logic [7:0]        r_blank, w_blank_d;

    logic [31:0]       w_sel;
    logic              w_cur_valid;
    logic [2:0]        w_lowest;
    logic [2:0]        w_next;
    logic [NSRC-1:0]   w_elig;
    logic [NSRC-1:0]   w_urg_onehot;
    logic [2:0]        w_urg_idx;

    // Nearest valid index strictly above cur, wrapping; cur itself only as a last resort.
    function automatic logic [2:0] f_next_valid(input logic [2:0] cur, input logic [NSRC-1:0] v);
        logic [2:0] res;
        int         best;
        int         d;
        res  = cur;
        best = int'(NSRC) + 1;
        for (int j = 0; j < int'(NSRC); j++) begin
            d = (j + int'(NSRC) - int'(cur)) % int'(NSRC);
            if (d == 0) d = int'(NSRC);
            if (v[j] && d < best) begin
                best = d;
                res  = 3'(j);
            end
        end
        return res;
    endfunction

    always_comb begin
        w_sel       = '0;
        w_cur_valid = 1'b0;
        w_lowest    = '0;
        w_urg_idx   = '0;
        for (int k = 0; k < int'(NSRC); k++) begin
            if (r_page == 3'(k)) begin
                w_sel       = iSRC_DATA[k*32 +: 32];
                w_cur_valid = iSRC_VALID[k];
            end
        end
        for (int k = int'(NSRC) - 1; k >= 0; k--) begin
            if (iSRC_VALID[k]) w_lowest = 3'(k);
            if (w_elig[k])     w_urg_idx = 3'(k);
        end
    end

    assign w_next       = f_next_valid(r_page, iSRC_VALID);
    assign w_elig       = iURG_REQ & iSRC_VALID & r_armed;
    assign w_urg_onehot = w_elig & (~w_elig + NSRC'(1));

    always_comb begin
        w_mode_d  = r_mode;
        w_page_d  = r_page;
        w_dwell_d = r_dwell;
        w_hold_d  = r_hold;
        w_gnt_d   = r_gnt;
        // A request seen low re-arms its source; a new grant disarms it below.
        w_armed_d = r_armed | ~iURG_REQ;
        unique case (r_mode)
            StIdle: begin
                if (|iSRC_VALID) begin
                    w_mode_d  = StRotate;
                    w_page_d  = w_lowest;
                    w_dwell_d = '0;
                end
            end
            StRotate: begin
                if (!(|iSRC_VALID)) begin
                    w_mode_d  = StIdle;
                    w_dwell_d = '0;
                end else if (|w_elig) begin
                    w_mode_d  = StUrgent;
                    w_page_d  = w_urg_idx;
                    w_gnt_d   = w_urg_onehot;
                    w_hold_d  = '0;
                    w_armed_d = w_armed_d & ~w_urg_onehot;
                end else if (!w_cur_valid || (!iFREEZE && r_dwell == DW'(DWELL - 1))) begin
                    w_page_d  = w_next;
                    w_dwell_d = '0;
                end else if (!iFREEZE) begin
                    w_dwell_d = r_dwell + DW'(1);
                end
            end
            StUrgent: begin
                if (!w_cur_valid || r_hold == HW'(HOLD - 1)) begin
                    w_mode_d  = StRotate;
                    w_dwell_d = '0;
                    w_gnt_d   = '0;
                end else begin
                    w_hold_d = r_hold + HW'(1);
                end
            end
            default: begin
                w_mode_d = StIdle;
                w_gnt_d  = '0;
            end
        endcase
        w_digits_d = (w_mode_d == StIdle) ? 32'h0 : w_sel;
    end

`ifdef HEXSCHED_BLINK_EN
    localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [BW-1:0] r_blink_cnt, w_blink_cnt_d;
    logic          r_blink_ph, w_blink_ph_d;

    // Blink phase restarts dark-off on every grant and is parked off outside URGENT.
    always_comb begin
        w_blink_cnt_d = '0;
        w_blink_ph_d  = 1'b0;
        if (r_mode == StUrgent && w_mode_d == StUrgent) begin
            if (r_blink_cnt == BW'(BLINK_HALF - 1)) begin
                w_blink_ph_d = ~r_blink_ph;
            end else begin
                w_blink_cnt_d = r_blink_cnt + BW'(1);
                w_blink_ph_d  = r_blink_ph;
            end
        end
        w_blank_d = (w_mode_d == StIdle) ? 8'hFF : (w_blink_ph_d ? 8'hFF : 8'h00);
    end

    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else begin
            r_blink_cnt <= w_blink_cnt_d;
            r_blink_ph  <= w_blink_ph_d;
        end
    end
`else
    assign w_blank_d = (w_mode_d == StIdle) ? 8'hFF : 8'h00;
`endif

    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_mode   <= StIdle;
            r_page   <= '0;
            r_dwell  <= '0;
            r_hold   <= '0;
            r_armed  <= '1;
            r_gnt    <= '0;
            r_digits <= '0;
            r_blank  <= 8'hFF;
        end else begin
            r_mode   <= w_mode_d;
            r_page   <= w_page_d;
            r_dwell  <= w_dwell_d;
            r_hold   <= w_hold_d;
            r_armed  <= w_armed_d;
            r_gnt    <= w_gnt_d;
            r_digits <= w_digits_d;
            r_blank  <= w_blank_d;
        end
    end

    assign oURG_GNT = r_gnt;
    assign oDIGITS  = r_digits;
    assign oBLANK   = r_blank;
    assign oPAGE    = r_page;
    assign oMODE    = r_mode;

endmodule

// File: tb/tb_hex_page_sched.sv
// Self-checking bench for hex_page_sched: directed scenarios plus randomized traffic
// compared every cycle against a behavioural scheduler model.
module tb_hex_page_sched;

    localparam int unsigned NSRC       = 4;
    localparam int unsigned DWELL      = 4;
    localparam int unsigned HOLD       = 6;
    localparam int unsigned BLINK_HALF = 2;
`ifdef HEXSCHED_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NSRC*32-1:0]  src_data;
    logic [NSRC-1:0]     src_valid;
    logic [NSRC-1:0]     urg_req;
    logic                freeze;
    logic [NSRC-1:0]     urg_gnt;
    logic [31:0]         digits;
    logic [7:0]          blank;
    logic [2:0]          page;
    logic [1:0]          mode;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: mode 0 idle, 1 rotate, 2 urgent.
    int        m_mode, m_page, m_dwell, m_hold;
    bit [3:0]  m_armed;
    logic [31:0] m_digits;
    logic [7:0]  m_blank;
    logic [3:0]  m_gnt;

    hex_page_sched #(
        .NSRC       (NSRC),
        .DWELL      (DWELL),
        .HOLD       (HOLD),
        .BLINK_HALF (BLINK_HALF)
    ) u_dut (
        .iCLK_50    (clk),
        .iRST_N     (rst_n),
        .iSRC_DATA  (src_data),
        .iSRC_VALID (src_valid),
        .iURG_REQ   (urg_req),
        .oURG_GNT   (urg_gnt),
        .iFREEZE    (freeze),
        .oDIGITS    (digits),
        .oBLANK     (blank),
        .oPAGE      (page),
        .oMODE      (mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input int k);
        return src_data[k*32 +: 32];
    endfunction

    task automatic model_reset();
        m_mode = 0; m_page = 0; m_dwell = 0; m_hold = 0;
        m_armed = 4'hF; m_digits = '0; m_blank = 8'hFF; m_gnt = '0;
    endtask

    task automatic model_step();
        int nm, np, pick;
        bit [3:0] elig;
        nm = m_mode;
        np = m_page;
        elig = urg_req & src_valid & m_armed;
        m_armed = m_armed | ~urg_req;
        case (m_mode)
            0: if (src_valid != 0) begin
                for (int k = 3; k >= 0; k--) if (src_valid[k]) np = k;
                nm = 1; m_dwell = 0;
            end
            1: if (src_valid == 0) begin
                nm = 0;
            end else if (elig != 0) begin
                pick = 0;
                for (int k = 3; k >= 0; k--) if (elig[k]) pick = k;
                nm = 2; np = pick; m_hold = 0; m_armed[pick] = 1'b0;
            end else if (!src_valid[m_page] || (!freeze && m_dwell == DWELL - 1)) begin
                for (int o = NSRC; o >= 1; o--)
                    if (src_valid[(m_page + o) % NSRC]) np = (m_page + o) % NSRC;
                m_dwell = 0;
            end else if (!freeze) begin
                m_dwell++;
            end
            default: if (!src_valid[m_page] || m_hold == HOLD - 1) begin
                nm = 1; m_dwell = 0;
            end else begin
                m_hold++;
            end
        endcase
        m_digits = (nm == 0) ? 32'h0 : word(m_page);
        m_gnt    = (nm == 2) ? (4'b1 << np) : 4'b0;
        if (nm == 0)
            m_blank = 8'hFF;
        else if (nm == 2 && BLINK && ((m_hold / BLINK_HALF) % 2 == 1))
            m_blank = 8'hFF;
        else
            m_blank = 8'h00;
        m_mode = nm;
        m_page = np;
    endtask

    task automatic check_all();
        check("mode",   32'(mode),    32'(m_mode));
        check("page",   32'(page),    32'(m_page));
        check("gnt",    32'(urg_gnt), 32'(m_gnt));
        check("digits", digits,       m_digits);
        check("blank",  32'(blank),   32'(m_blank));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mode"},   32'(mode),    32'd0);
        check({tag, "_page"},   32'(page),    32'd0);
        check({tag, "_gnt"},    32'(urg_gnt), 32'd0);
        check({tag, "_digits"}, digits,       32'd0);
        check({tag, "_blank"},  32'(blank),   32'hFF);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_mode(input logic [1:0] want, input string tag);
        for (int i = 0; i < 40; i++) begin
            if (mode == want) break;
            cycle();
        end
        check(tag, 32'(mode), 32'(want));
    endtask

    int g1, g2, gx;

    initial begin
        src_data = '0; src_valid = '0; urg_req = '0; freeze = 1'b0;
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset_vals("por");
        repeat (2) cycle();
        rst_n = 1'b1;

        // Nothing valid: stays idle and dark.
        repeat (20) cycle();

        // Rotation over 0,1,3 with constant per-source data.
        for (int k = 0; k < 4; k++) src_data[k*32 +: 32] = {4{4'(k), 4'h0}};
        src_valid = 4'b1011;
        repeat (20) cycle();

        // Freeze while on page 1.
        for (int i = 0; i < 20 && page != 3'd1; i++) cycle();
        check("freeze_start", 32'(page), 32'd1);
        freeze = 1'b1;
        repeat (10) cycle();
        check("freeze_hold", 32'(page), 32'd1);
        freeze = 1'b0;
        repeat (12) cycle();

        // Stuck requests on 1 and 2: one grant each, then nothing.
        src_valid = 4'b1111;
        urg_req = 4'b0110;
        g1 = 0; g2 = 0; gx = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (urg_gnt == 4'b0010) g1++;
            else if (urg_gnt == 4'b0100) g2++;
            else if (urg_gnt != 4'b0000) gx++;
        end
        check("stuck_g1", 32'(g1), 32'd6);
        check("stuck_g2", 32'(g2), 32'd6);
        check("stuck_gx", 32'(gx), 32'd0);
        urg_req = 4'b0000;
        cycle();
        urg_req = 4'b0010;
        wait_mode(2'd2, "rearm_grant");
        check("rearm_gnt", 32'(urg_gnt), 32'h2);
        repeat (8) cycle();

        // Granted source drops valid mid-hold.
        urg_req = 4'b0001;
        wait_mode(2'd2, "drop_grant");
        cycle();
        src_valid[0] = 1'b0;
        cycle();
        check("drop_exit", 32'(mode), 32'd1);
        repeat (6) cycle();
        urg_req = '0;

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) src_valid[$urandom_range(0, 3)] ^= 1'b1;
            for (int k = 0; k < 4; k++) urg_req[k] = ($urandom_range(0, 7) == 0);
            freeze = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) src_data[$urandom_range(0, 3)*32 +: 32] = $urandom;
            cycle();
        end

        // Asynchronous reset in the middle of a grant.
        freeze = 1'b0;
        src_valid = 4'b1111;
        urg_req = 4'b0000;
        repeat (2) cycle();
        urg_req = 4'b1000;
        wait_mode(2'd2, "arst_grant");
        cycle();
        #2 rst_n = 1'b0;
        #1 check_reset_vals("arst");
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
        urg_req = 4'b0000;
        repeat (20) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
